// File: rtl/spi_reply_framer_if.sv
// Bundle between the reply framer, the per-slave reply FIFOs and the host transmit FIFO.
// The framer takes the master side; the FIFOs and host path take the slave side.
interface spi_reply_framer_if #(
   parameter int N_SLAVES = 3
);
   logic [N_SLAVES-1:0]   have_msg_bus;
   logic [8*N_SLAVES-1:0] len_bus;
   logic [8*N_SLAVES-1:0] s_dout_bus;
   logic [N_SLAVES-1:0]   s_rdreq_bus;
   logic [7:0]            tx_data;
   logic                  tx_wrreq;
   logic                  tx_full;
   logic                  busy;

   modport master (
      input  have_msg_bus, len_bus, s_dout_bus, tx_full,
      output s_rdreq_bus, tx_data, tx_wrreq, busy
   );

   modport slave (
      output have_msg_bus, len_bus, s_dout_bus, tx_full,
      input  s_rdreq_bus, tx_data, tx_wrreq, busy
   );
endinterface

// File: rtl/spi_reply_framer.sv
// Round-robin drain of per-slave SPI reply FIFOs into one host byte stream, framed as
// SYNC, ADDR, LEN, payload, XOR checksum (the checksum covers everything except SYNC).
module spi_reply_framer #(
   parameter int         N_SLAVES  = 3,
   parameter logic [7:0] SYNC_BYTE = 8'h5A,
   parameter logic [7:0] ADDR_BASE = 8'h10
) (
   input logic                clk,
   input logic                n_rst,
   spi_reply_framer_if.master bus
);
   localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

   typedef enum logic [2:0] {IDLE, SYNC, ADDR, LEN, RD, WR, CSUM} state_t;

   state_t        state_q;
   logic [SW-1:0] sel_q;
   logic [SW-1:0] start_q;
   logic [6:0]    cnt_q;
   logic [7:0]    chk_q;

   logic [7:0]    len_arr  [N_SLAVES];
   logic [7:0]    dout_arr [N_SLAVES];
   logic          grant;
   logic [SW-1:0] grant_idx;
   logic [7:0]    grant_len;
   logic [6:0]    grant_cnt;
   logic [7:0]    addr_byte;
   logic [7:0]    len_byte;
   logic [7:0]    pay_byte;
   logic          unused_len_hi;

   always_comb begin
      for (int i = 0; i < N_SLAVES; i++) begin
         len_arr[i]  = bus.len_bus[8*i +: 8];
         dout_arr[i] = bus.s_dout_bus[8*i +: 8];
      end
   end

   // Walk from the highest offset down so the lowest offset after start_q wins.
   always_comb begin : arb
      int            idx;
      logic [SW-1:0] cand;
      grant     = 1'b0;
      grant_idx = '0;
      idx       = 0;
      cand      = '0;
      for (int k = N_SLAVES - 1; k >= 0; k--) begin
         idx = int'(start_q) + k;
         if (idx >= N_SLAVES) idx = idx - N_SLAVES;
         cand = idx[SW-1:0];
         if (bus.have_msg_bus[cand]) begin
            grant     = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // A used-word count of 0 with have_msg high means the FIFO holds 64 words.
   assign grant_len     = len_arr[grant_idx];
   assign grant_cnt     = (grant_len[5:0] == 6'd0) ? 7'd64 : {1'b0, grant_len[5:0]};
   assign unused_len_hi = ^grant_len[7:6];

   assign addr_byte = ADDR_BASE + 8'(sel_q);
   assign len_byte  = {1'b0, cnt_q};
   assign pay_byte  = dout_arr[sel_q];

   always_comb begin
      bus.tx_data     = 8'h00;
      bus.tx_wrreq    = 1'b0;
      bus.s_rdreq_bus = '0;
      bus.busy        = (state_q != IDLE);
      case (state_q)
         SYNC: begin bus.tx_data = SYNC_BYTE; bus.tx_wrreq = !bus.tx_full; end
         ADDR: begin bus.tx_data = addr_byte; bus.tx_wrreq = !bus.tx_full; end
         LEN:  begin bus.tx_data = len_byte;  bus.tx_wrreq = !bus.tx_full; end
         WR:   begin bus.tx_data = pay_byte;  bus.tx_wrreq = !bus.tx_full; end
         CSUM: begin bus.tx_data = chk_q;     bus.tx_wrreq = !bus.tx_full; end
         RD:   bus.s_rdreq_bus[sel_q] = !bus.tx_full;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         start_q <= '0;
         cnt_q   <= '0;
         chk_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (grant) begin
               sel_q   <= grant_idx;
               cnt_q   <= grant_cnt;
               chk_q   <= 8'h00;
               state_q <= SYNC;
            end
            SYNC: if (!bus.tx_full) state_q <= ADDR;
            ADDR: if (!bus.tx_full) begin
               chk_q   <= chk_q ^ addr_byte;
               state_q <= LEN;
            end
            LEN: if (!bus.tx_full) begin
               chk_q   <= chk_q ^ len_byte;
               state_q <= RD;
            end
            RD: if (!bus.tx_full) state_q <= WR;
            // FIFO q holds while stalled here since no new rdreq is issued.
            WR: if (!bus.tx_full) begin
               chk_q   <= chk_q ^ pay_byte;
               cnt_q   <= cnt_q - 7'd1;
               state_q <= (cnt_q == 7'd1) ? CSUM : RD;
            end
            CSUM: if (!bus.tx_full) begin
               start_q <= (sel_q == SW'(N_SLAVES - 1)) ? '0 : sel_q + 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_reply_framer.sv
// Bench for spi_reply_framer: queue-based reply FIFO models, random payloads, and a
// frame-level reference model (round-robin pick plus byte-list framing).
module tb_spi_reply_framer;
   localparam int         N      = 3;
   localparam logic [7:0] SYNC_B = 8'h5A;
   localparam logic [7:0] ABASE  = 8'h10;

   typedef logic [7:0] bq_t [$];

   logic clk   = 1'b0;
   logic n_rst = 1'b1;

   spi_reply_framer_if #(.N_SLAVES(N)) bus ();

   spi_reply_framer #(
      .N_SLAVES (N),
      .SYNC_BYTE(SYNC_B),
      .ADDR_BASE(ABASE)
   ) dut (
      .clk  (clk),
      .n_rst(n_rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   bq_t          fq [N];
   bq_t          got;
   bq_t          exp_s;
   int           gotcyc [$];
   int           rdcnt [N];
   int           cyc        = 0;
   int           hm_rise    = -1;
   int           viol       = 0;
   int           underflow  = 0;
   int           model_next = 0;
   int           total      = 0;
   int           bad        = 0;
   logic [N-1:0] hm_prev    = '0;

   // Reply FIFO models (q valid the cycle after rdreq) plus host-side write capture.
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < N; i++) fq[i].delete();
         hm_prev = '0;
         bus.have_msg_bus <= '0;
         bus.len_bus      <= '0;
         bus.s_dout_bus   <= '0;
      end else begin
         if (bus.tx_wrreq) begin
            got.push_back(bus.tx_data);
            gotcyc.push_back(cyc);
            if (bus.tx_full) viol++;
         end
         if (bus.tx_full && (bus.s_rdreq_bus != '0)) viol++;
         if ($countones(bus.s_rdreq_bus) > 1) viol++;
         if (bus.have_msg_bus != '0 && hm_prev == '0) hm_rise = cyc;
         hm_prev = bus.have_msg_bus;
         for (int i = 0; i < N; i++) begin
            if (bus.s_rdreq_bus[i]) begin
               rdcnt[i]++;
               if (fq[i].size() == 0) underflow++;
               else bus.s_dout_bus[8*i +: 8] <= fq[i].pop_front();
            end
            bus.have_msg_bus[i]     <= (fq[i].size() != 0);
            bus.len_bus[8*i +: 8]   <= 8'(fq[i].size()) & 8'h3F;
         end
         cyc++;
      end
   end

   function automatic bq_t rand_bytes(int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   function automatic void load(int s, bq_t pl);
      foreach (pl[i]) fq[s].push_back(pl[i]);
   endfunction

   function automatic int rr_pick(logic [N-1:0] pend);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (model_next + k) % N;
         if (pend[idx]) return idx;
      end
      return -1;
   endfunction

   // Expected frame for one reply of payload pl from slave s.
   function automatic void add_frame(int s, bq_t pl);
      logic [7:0] a, l, c;
      a = ABASE + 8'(s);
      l = 8'(pl.size());
      c = a ^ l;
      exp_s.push_back(SYNC_B);
      exp_s.push_back(a);
      exp_s.push_back(l);
      foreach (pl[i]) begin
         exp_s.push_back(pl[i]);
         c = c ^ pl[i];
      end
      exp_s.push_back(c);
      model_next = (s + 1) % N;
   endfunction

   function automatic int diff_idx();
      int n;
      n = (got.size() < exp_s.size()) ? got.size() : exp_s.size();
      for (int i = 0; i < n; i++) if (got[i] !== exp_s[i]) return i;
      if (got.size() != exp_s.size()) return n;
      return -1;
   endfunction

   function automatic string byte_at(bq_t q, int i);
      if (i >= 0 && i < q.size()) return $sformatf("%02h", q[i]);
      return "--";
   endfunction

   task automatic start_case();
      @(negedge clk);
      got.delete();
      exp_s.delete();
      gotcyc.delete();
      foreach (rdcnt[i]) rdcnt[i] = 0;
      hm_rise = -1;
   endtask

   task automatic wait_done(input int n, input int budget, input bit rnd_full, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         bus.tx_full = rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0;
         if (got.size() >= n && !bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      bus.tx_full = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      #2 n_rst = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.tx_wrreq !== 1'b0) begin bad++; $display("FAIL reset_wrreq: actual %b required 0", bus.tx_wrreq); end
      total++; if (bus.s_rdreq_bus !== '0) begin bad++; $display("FAIL reset_rdreq: actual %b required 000", bus.s_rdreq_bus); end
      total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_txdata: actual %h required 00", bus.tx_data); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: actual %b required 0", bus.busy); end
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      bq_t pl;
      bit  ok;
      int  d, off;
      start_case();
      pl = {8'h01, 8'h02};
      load(1, pl);
      add_frame(rr_pick(3'b010), pl);
      wait_done(exp_s.size(), 200, 1'b0, ok);
      total++; d = diff_idx();
      if (!ok || d >= 0) begin bad++; $display("FAIL single_stream: ok %0d idx %0d actual %s required %s (%0d vs %0d bytes)", ok, d, byte_at(got, d), byte_at(exp_s, d), got.size(), exp_s.size()); end
      total++; if (rdcnt[1] != 2) begin bad++; $display("FAIL single_rdreq: actual %0d required 2", rdcnt[1]); end
      off = (gotcyc.size() > 0) ? gotcyc[$] - hm_rise : -1;
      total++; if (off != 4 + 2 * 2) begin bad++; $display("FAIL single_csum_cycle: actual %0d required %0d", off, 4 + 2 * 2); end
   endtask

   task automatic test_round_robin();
      bq_t a, b;
      bit  ok;
      int  d, s;
      start_case();
      a = rand_bytes(1);
      load(0, a);
      add_frame(rr_pick(3'b001), a);
      wait_done(exp_s.size(), 200, 1'b0, ok);
      total++; d = diff_idx();
      if (!ok || d >= 0) begin bad++; $display("FAIL rr_prior: ok %0d idx %0d actual %s required %s", ok, d, byte_at(got, d), byte_at(exp_s, d)); end
      start_case();
      a = rand_bytes(1);
      b = rand_bytes(1);
      load(0, a);
      load(2, b);
      s = rr_pick(3'b101);
      add_frame(s, (s == 2) ? b : a);
      s = rr_pick((s == 2) ? 3'b001 : 3'b100);
      add_frame(s, (s == 2) ? b : a);
      wait_done(exp_s.size(), 300, 1'b0, ok);
      total++; d = diff_idx();
      if (!ok || d >= 0) begin bad++; $display("FAIL rr_order: ok %0d idx %0d actual %s required %s", ok, d, byte_at(got, d), byte_at(exp_s, d)); end
   endtask

   task automatic test_backpressure();
      bq_t pl;
      int  s, d, v0, len_c;
      bit  ok;
      start_case();
      v0 = viol;
      s  = $urandom_range(0, N - 1);
      pl = rand_bytes(3);
      load(s, pl);
      add_frame(s, pl);
      ok = 1'b0;
      // Stalls land in SYNC (k=2), RD (k=6) and WR (k=8) counted from the load negedge.
      for (int k = 1; k < 200; k++) begin
         @(negedge clk);
         bus.tx_full = (k == 2 || k == 6 || k == 8);
         if (k > 8 && got.size() >= exp_s.size() && !bus.busy) begin ok = 1'b1; break; end
      end
      bus.tx_full = 1'b0;
      repeat (3) @(negedge clk);
      total++; d = diff_idx();
      if (!ok || d >= 0) begin bad++; $display("FAIL bp_stream: ok %0d idx %0d actual %s required %s", ok, d, byte_at(got, d), byte_at(exp_s, d)); end
      len_c = (gotcyc.size() > 0) ? gotcyc[$] - hm_rise : -1;
      total++; if (len_c != 4 + 2 * 3 + 3) begin bad++; $display("FAIL bp_length: actual %0d required %0d", len_c, 4 + 2 * 3 + 3); end
      total++; if (viol != v0) begin bad++; $display("FAIL bp_write_while_full: actual %0d required %0d", viol, v0); end
   endtask

   task automatic test_full_fifo();
      bq_t pl;
      int  s, d;
      bit  ok;
      start_case();
      s  = $urandom_range(0, N - 1);
      pl = rand_bytes(64);
      load(s, pl);
      add_frame(s, pl);
      wait_done(exp_s.size(), 1000, 1'b0, ok);
      total++; d = diff_idx();
      if (!ok || d >= 0) begin bad++; $display("FAIL full64_stream: ok %0d idx %0d actual %s required %s", ok, d, byte_at(got, d), byte_at(exp_s, d)); end
      total++; if (rdcnt[s] != 64) begin bad++; $display("FAIL full64_rdreq: actual %0d required 64", rdcnt[s]); end
   endtask

   task automatic test_reset_mid();
      bq_t a, b;
      int  d, s;
      bit  ok;
      start_case();
      a = rand_bytes(1);
      load(0, a);
      add_frame(rr_pick(3'b001), a);
      wait_done(exp_s.size(), 200, 1'b0, ok);
      total++; d = diff_idx();
      if (!ok || d >= 0) begin bad++; $display("FAIL rm_prior: ok %0d idx %0d actual %s required %s", ok, d, byte_at(got, d), byte_at(exp_s, d)); end
      start_case();
      load(2, rand_bytes(4));
      // k=8 falls in the cycle writing payload byte 2.
      for (int k = 1; k <= 8; k++) @(negedge clk);
      n_rst = 1'b0;
      #1;
      total++; if (bus.tx_wrreq !== 1'b0) begin bad++; $display("FAIL rm_wrreq: actual %b required 0", bus.tx_wrreq); end
      total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rm_txdata: actual %h required 00", bus.tx_data); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rm_busy: actual %b required 0", bus.busy); end
      total++; if (bus.s_rdreq_bus !== '0) begin bad++; $display("FAIL rm_rdreq: actual %b required 000", bus.s_rdreq_bus); end
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      model_next = 0;
      start_case();
      a = rand_bytes($urandom_range(1, 3));
      b = rand_bytes($urandom_range(1, 3));
      load(0, a);
      load(1, b);
      s = rr_pick(3'b011);
      add_frame(s, (s == 0) ? a : b);
      s = rr_pick((s == 0) ? 3'b010 : 3'b001);
      add_frame(s, (s == 0) ? a : b);
      wait_done(exp_s.size(), 300, 1'b0, ok);
      total++; d = diff_idx();
      if (!ok || d >= 0) begin bad++; $display("FAIL rm_restart: ok %0d idx %0d actual %s required %s", ok, d, byte_at(got, d), byte_at(exp_s, d)); end
   endtask

   task automatic test_mid_arrival();
      bq_t a, b;
      int  d;
      bit  ok;
      start_case();
      a = rand_bytes(2);
      b = rand_bytes(3);
      load(0, a);
      add_frame(rr_pick(3'b001), a);
      repeat (4) @(negedge clk);
      load(0, b);
      add_frame(rr_pick(3'b001), b);
      wait_done(exp_s.size(), 300, 1'b0, ok);
      total++; d = diff_idx();
      if (!ok || d >= 0) begin bad++; $display("FAIL mid_arrival: ok %0d idx %0d actual %s required %s", ok, d, byte_at(got, d), byte_at(exp_s, d)); end
   endtask

   task automatic test_random();
      bq_t          pls [N];
      logic [N-1:0] pend;
      int           s, d;
      bit           ok;
      for (int it = 0; it < 6; it++) begin
         start_case();
         pend = '0;
         for (int i = 0; i < N; i++) begin
            pls[i] = rand_bytes($urandom_range(0, 6));
            if (pls[i].size() != 0) pend[i] = 1'b1;
         end
         if (pend == '0) begin
            s = $urandom_range(0, N - 1);
            pls[s] = rand_bytes(1);
            pend[s] = 1'b1;
         end
         for (int i = 0; i < N; i++) load(i, pls[i]);
         while (pend != '0) begin
            s = rr_pick(pend);
            add_frame(s, pls[s]);
            pend[s] = 1'b0;
         end
         wait_done(exp_s.size(), 2000, 1'b1, ok);
         total++; d = diff_idx();
         if (!ok || d >= 0) begin bad++; $display("FAIL random_%0d: ok %0d idx %0d actual %s required %s", it, ok, d, byte_at(got, d), byte_at(exp_s, d)); end
      end
   endtask

   initial begin
      bus.tx_full = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_full_fifo();
      test_reset_mid();
      test_mid_arrival();
      test_random();
      total++; if (viol != 0) begin bad++; $display("FAIL protocol_violations: actual %0d required 0", viol); end
      total++; if (underflow != 0) begin bad++; $display("FAIL fifo_underflow: actual %0d required 0", underflow); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
